instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 158 +++++++++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: 2-entry {pc, instr} FIFO over a fixed 1-cycle-latency instruction memory.
// Optional IFETCH_BYPASS_EN forwards a response straight to if_* when the FIFO is empty.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        imem_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready
);
   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_epoch_q, out_epoch_d;
   logic        epoch_q, epoch_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
   logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

   logic        run, redirect, resp_hit, resp_fail;
   logic        bypass, pop, fifo_pop, push, issue;
   logic [2:0]  demand;

   assign run       = (state_q == ST_RUN);
   assign redirect  = run & redirect_valid;
   assign resp_hit  = out_valid_q & (out_epoch_q == epoch_q) & imem_valid;
   assign resp_fail = out_valid_q & (out_epoch_q == epoch_q) & ~imem_valid;

`ifdef IFETCH_BYPASS_EN
   assign bypass = resp_hit & (count_q == 2'd0);
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      if_valid = 1'b0;
      if_instr = NOP_INSTR;
      if_pc    = '0;
      if (count_q != 2'd0) begin
         if_valid = 1'b1;
         if_instr = ins0_q;
         if_pc    = pc0_q;
      end else if (bypass) begin
         if_valid = 1'b1;
         if_instr = imem_data;
         if_pc    = out_pc_q;
      end
   end

   assign pop      = if_valid & if_ready;
   assign fifo_pop = pop & (count_q != 2'd0);
   // A bypassed word that decode takes this cycle must not also land in the FIFO.
   assign push     = resp_hit & ~redirect & ~(bypass & if_ready);
   assign demand   = {1'b0, count_q} + {2'b00, out_valid_q} - {2'b00, pop};
   assign issue    = run & ~redirect & ~resp_fail & (demand < 3'd2);
   assign imem_addr = fetch_pc_q;

   always_comb begin
      state_d     = ST_RUN;
      fetch_pc_d  = fetch_pc_q;
      out_valid_d = 1'b0;
      out_pc_d    = out_pc_q;
      out_epoch_d = out_epoch_q;
      epoch_d     = epoch_q;
      if (redirect) begin
         epoch_d    = ~epoch_q;
         fetch_pc_d = redirect_pc;
      end else if (resp_fail) begin
         fetch_pc_d = out_pc_q;
      end else if (issue) begin
         fetch_pc_d  = fetch_pc_q + 32'd4;
         out_valid_d = 1'b1;
         out_pc_d    = fetch_pc_q;
         out_epoch_d = epoch_q;
      end
   end

   always_comb begin
      count_d = count_q;
      pc0_d   = pc0_q;
      pc1_d   = pc1_q;
      ins0_d  = ins0_q;
      ins1_d  = ins1_q;
      if (redirect) begin
         count_d = 2'd0;
      end else begin
         case ({push, fifo_pop})
            2'b01: begin
               pc0_d   = pc1_q;
               ins0_d  = ins1_q;
               count_d = count_q - 2'd1;
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  pc0_d  = out_pc_q;
                  ins0_d = imem_data;
               end else begin
                  pc1_d  = out_pc_q;
                  ins1_d = imem_data;
               end
               count_d = count_q + 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  pc0_d  = out_pc_q;
                  ins0_d = imem_data;
               end else begin
                  pc0_d  = pc1_q;
                  ins0_d = ins1_q;
                  pc1_d  = out_pc_q;
                  ins1_d = imem_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_BOOT;
         fetch_pc_q  <= RESET_PC;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_epoch_q <= 1'b0;
         epoch_q     <= 1'b0;
         count_q     <= 2'd0;
         pc0_q       <= '0;
         pc1_q       <= '0;
         ins0_q      <= '0;
         ins1_q      <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_epoch_q <= out_epoch_d;
         epoch_q     <= epoch_d;
         count_q     <= count_d;
         pc0_q       <= pc0_d;
         pc1_q       <= pc1_d;
         ins0_q      <= ins0_d;
         ins1_q      <= ins1_d;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected pc stream queued at stimulus time, popped on each transfer.
module tb_instr_fetch;
   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
   localparam int unsigned EXP_LAT = 2;
`else
   localparam int unsigned EXP_LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data = '0;
   logic        imem_valid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned deliv_cnt = 0;
   logic [31:0] exp_q[$];
   logic        ready_en = 1'b1;
   logic        drop_arm = 1'b0;
   logic [31:0] drop_pc = '0;
   logic [31:0] addr_s = '0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_valid(imem_valid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
   );

   function automatic logic [31:0] tag(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: address seen mid-cycle is answered one edge later.
   always @(negedge clk) addr_s = imem_addr;
   always @(posedge clk) begin
      #1;
      imem_data = tag(addr_s);
      if (drop_arm && addr_s == drop_pc) begin
         imem_valid = 1'b0;
         drop_arm   = 1'b0;
      end else begin
         imem_valid = 1'b1;
      end
   end

   always @(posedge clk) begin
      #2;
      if_ready = ready_en && (exp_q.size() != 0);
   end

   always @(negedge clk) begin
      if (if_valid && if_ready) begin
         deliv_cnt++;
         check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check_eq("if_pc", if_pc, e);
            check_eq("if_instr", if_instr, tag(e));
         end
      end
      if (!if_valid) begin
         check_eq("idle_instr", if_instr, NOP);
         check_eq("idle_pc", if_pc, 32'd0);
      end
   end

   task automatic push_seq(input logic [31:0] start, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) exp_q.push_back(start + 32'(i) * 32'd4);
   endtask

   task automatic wait_drain(input int unsigned budget);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic measure_first_valid();
      int unsigned n = 0;
      int unsigned snap;
      logic seen = 1'b0;
      while (!seen && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk); #1;
         seen = if_valid;
      end
      check_eq("first_valid_lat", n, EXP_LAT);
      snap = deliv_cnt;
      repeat (3) @(negedge clk);
      #1;
      check_eq("throughput", deliv_cnt - snap, 32'd3);
   endtask

   task automatic hold_check(input logic [31:0] pc, input int unsigned cycles);
      for (int unsigned i = 0; i < cycles; i++) begin
         @(negedge clk); #1;
         check_eq("hold_valid", {31'd0, if_valid}, 32'd1);
         check_eq("hold_pc", if_pc, pc);
         check_eq("hold_instr", if_instr, tag(pc));
      end
   endtask

   task automatic do_redirect(input logic [31:0] target, input int unsigned n);
      @(posedge clk); #2;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(negedge clk); #1;
      exp_q.delete();
      push_seq(target, n);
      @(posedge clk); #2;
      redirect_valid = 1'b0;
      @(negedge clk); #1;
      check_eq("post_redirect_valid", {31'd0, if_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #2;
      check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("rst_instr", if_instr, NOP);
      check_eq("rst_pc", if_pc, 32'd0);
      check_eq("rst_addr", imem_addr, RST_PC);

      // Start-up, wrap through zero
      push_seq(RST_PC, 4);
      @(posedge clk); #2;
      reset = 1'b1;
      measure_first_valid();
      wait_drain(40);

      // Back-pressure: FIFO fills with 0x8/0xC and must hold steady
      repeat (3) @(posedge clk);
      hold_check(32'h8, 5);

      // Redirect while full; 0x48 response dropped once by memory
      drop_pc  = 32'h48;
      drop_arm = 1'b1;
      do_redirect(32'h40, 8);
      wait_drain(60);
      check_eq("drop_used", {31'd0, drop_arm}, 32'd0);

      repeat (3) @(posedge clk);
      hold_check(32'h60, 5);
      push_seq(32'h60, 4);
      wait_drain(40);

      // Redirect while streaming, with a transfer in the same cycle
      push_seq(32'h70, 16);
      repeat (6) @(posedge clk);
      do_redirect(32'h200, 6);
      wait_drain(40);

      // Reset pulse mid-stream
      push_seq(32'h218, 16);
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst_valid", {31'd0, if_valid}, 32'd0);
      check_eq("async_rst_addr", imem_addr, RST_PC);
      check_eq("async_rst_pc", if_pc, 32'd0);
      check_eq("async_rst_instr", if_instr, NOP);
      exp_q.delete();
      push_seq(RST_PC, 6);
      @(posedge clk); #2;
      reset = 1'b1;
      measure_first_valid();
      wait_drain(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
